// File: rtl/circle_engine.sv
// Midpoint circle-outline engine: latches centre/radius/colour on start, emits one
// clipped candidate pixel per clock across eight octants, then holds done until start drops.
module circle_engine #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] centre_x,
   input  logic [6:0] centre_y,
   input  logic [7:0] radius,
   input  logic [2:0] colour,
   output logic       done,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot
);

   typedef enum logic [1:0] {
      IDLE,
      DRAW,
      DONE
   } state_t;

   localparam logic signed [10:0] X_LIM = 11'(SCREEN_W);
   localparam logic signed [10:0] Y_LIM = 11'(SCREEN_H);

   state_t            state_reg, state_next;
   logic [7:0]        cx_reg, cx_next;
   logic [6:0]        cy_reg, cy_next;
   logic [2:0]        colour_reg, colour_next;
   logic signed [10:0] ox_reg, ox_next;
   logic signed [10:0] oy_reg, oy_next;
   logic signed [11:0] crit_reg, crit_next;
   logic [2:0]        oct_reg, oct_next;

   logic              done_reg, done_next;
   logic              plot_reg, plot_next;
   logic [7:0]        x_reg, x_next;
   logic [6:0]        y_reg, y_next;
   logic [2:0]        col_out_reg, col_out_next;

   logic signed [10:0] cx_s, cy_s;
   logic signed [10:0] cand_x [8];
   logic signed [10:0] cand_y [8];
   logic [7:0]         on_screen;

   assign cx_s = signed'({3'b000, cx_reg});
   assign cy_s = signed'({4'b0000, cy_reg});

   // Octant gi: odd octants swap ox/oy, octants 2..5 mirror x, octants 4..7 mirror y.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_oct
         localparam bit SWAP  = (gi % 2) == 1;
         localparam bit NEG_X = (gi >= 2) && (gi <= 5);
         localparam bit NEG_Y = (gi >= 4);
         logic signed [10:0] dx, dy;
         assign dx = SWAP ? oy_reg : ox_reg;
         assign dy = SWAP ? ox_reg : oy_reg;
         assign cand_x[gi] = NEG_X ? (cx_s - dx) : (cx_s + dx);
         assign cand_y[gi] = NEG_Y ? (cy_s - dy) : (cy_s + dy);
         assign on_screen[gi] = (cand_x[gi] >= 11'sd0) && (cand_x[gi] < X_LIM) &&
                                (cand_y[gi] >= 11'sd0) && (cand_y[gi] < Y_LIM);
      end
   endgenerate

   // Decision-variable update candidates, evaluated once per loop pass at octant 7.
   logic signed [10:0] oy_inc, ox_dec;
   logic signed [11:0] oy_inc_ext, ox_dec_ext;
   logic signed [11:0] crit_inside, crit_outside;
   logic               step_in;

   assign oy_inc       = oy_reg + 11'sd1;
   assign ox_dec       = ox_reg - 11'sd1;
   assign oy_inc_ext   = {oy_inc[10], oy_inc};
   assign ox_dec_ext   = {ox_dec[10], ox_dec};
   assign crit_inside  = crit_reg + (oy_inc_ext <<< 1) + 12'sd1;
   assign crit_outside = crit_reg + ((oy_inc_ext - ox_dec_ext) <<< 1) + 12'sd1;
   assign step_in      = (crit_reg <= 12'sd0);

   always_comb begin
      state_next   = state_reg;
      cx_next      = cx_reg;
      cy_next      = cy_reg;
      colour_next  = colour_reg;
      ox_next      = ox_reg;
      oy_next      = oy_reg;
      crit_next    = crit_reg;
      oct_next     = oct_reg;
      done_next    = 1'b0;
      plot_next    = 1'b0;
      x_next       = x_reg;
      y_next       = y_reg;
      col_out_next = col_out_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               cx_next     = centre_x;
               cy_next     = centre_y;
               colour_next = colour;
               ox_next     = signed'({3'b000, radius});
               oy_next     = 11'sd0;
               crit_next   = 12'sd1 - signed'({4'b0000, radius});
               oct_next    = 3'd0;
               state_next  = DRAW;
            end
         end
         DRAW: begin
            plot_next = on_screen[oct_reg];
            if (on_screen[oct_reg]) begin
               x_next       = cand_x[oct_reg][7:0];
               y_next       = cand_y[oct_reg][6:0];
               col_out_next = colour_reg;
            end
            oct_next = oct_reg + 3'd1;
            if (oct_reg == 3'd7) begin
               oy_next = oy_inc;
               if (step_in) begin
                  crit_next = crit_inside;
               end else begin
                  ox_next   = ox_dec;
                  crit_next = crit_outside;
               end
               if (oy_inc > (step_in ? ox_reg : ox_dec)) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            // Held start keeps done asserted; a new drawing needs a pass through IDLE.
            if (start) begin
               done_next = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         cx_reg      <= '0;
         cy_reg      <= '0;
         colour_reg  <= '0;
         ox_reg      <= '0;
         oy_reg      <= '0;
         crit_reg    <= '0;
         oct_reg     <= '0;
         done_reg    <= 1'b0;
         plot_reg    <= 1'b0;
         x_reg       <= '0;
         y_reg       <= '0;
         col_out_reg <= '0;
      end else begin
         state_reg   <= state_next;
         cx_reg      <= cx_next;
         cy_reg      <= cy_next;
         colour_reg  <= colour_next;
         ox_reg      <= ox_next;
         oy_reg      <= oy_next;
         crit_reg    <= crit_next;
         oct_reg     <= oct_next;
         done_reg    <= done_next;
         plot_reg    <= plot_next;
         x_reg       <= x_next;
         y_reg       <= y_next;
         col_out_reg <= col_out_next;
      end
   end

   assign done       = done_reg;
   assign vga_plot   = plot_reg;
   assign vga_x      = x_reg;
   assign vga_y      = y_reg;
   assign vga_colour = col_out_reg;

endmodule

// File: doc/circle_engine.md
# circle_engine

Midpoint (Bresenham) circle-outline drawing engine that serves the start/done drawing handshake driven by the team's shape test sequences and by the top-level shape FSMs. It latches a centre, radius and colour on `start`, emits one candidate pixel per clock toward the VGA adapter, and suppresses any pixel outside the 160×120 screen. It then raises `done` and holds it until `start` is dropped. Triangle and other shape drawers reuse it as their arc primitive.

## Interface
Parameters:
- SCREEN_W, 160, visible width; pixels with x ≥ SCREEN_W are not plotted
- SCREEN_H, 120, visible height; pixels with y ≥ SCREEN_H are not plotted

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; level-held by requester until `done` is seen
- centre_x  in  8  centre column, 0–255; values 160–255 are legal and off-screen
- centre_y  in  7  centre row, 0–127; values 120–127 are legal and off-screen
- radius  in  8  radius in pixels, 0–255
- colour  in  3  pixel colour
- done  out  1  high while the finished drawing is acknowledged
- vga_x  out  8  pixel column
- vga_y  out  7  pixel row
- vga_colour  out  3  pixel colour
- vga_plot  out  1  write strobe; `vga_x`, `vga_y` and `vga_colour` are valid when it is high

## Operation
- States: IDLE, DRAW, DONE.
- IDLE
  - `start`=1 at a posedge latches `centre_x`, `centre_y`, `radius` and `colour`.
  - It also sets ox=radius, oy=0, crit=1−radius and oct=0, then moves to DRAW.
  - Inputs are ignored after latching.
- DRAW issues one octant per cycle, oct 0..7, in this order:
  - (cx+ox, cy+oy), (cx+oy, cy+ox), (cx−ox, cy+oy), (cx−oy, cy+ox)
  - (cx−ox, cy−oy), (cx−oy, cy−ox), (cx+ox, cy−oy), (cx+oy, cy−ox)
- Clipping: the candidate is plotted only if 0 ≤ x < SCREEN_W and 0 ≤ y < SCREEN_H.
  - Otherwise `vga_plot`=0 for that cycle.
  - The cycle is still consumed, so there is no skipping.
- At oct=7 the engine updates its variables:
  - oy ← oy+1.
  - If crit ≤ 0: crit ← crit + 2·oy_new + 1.
  - Else: ox ← ox−1 and crit ← crit + 2·(oy_new − ox_new) + 1.
  - If oy_new > ox_new, go to DONE; otherwise set oct=0 and continue.
- DONE: `done`=1. It stays in DONE while `start`=1. `start`=0 moves it to IDLE, and `done` falls on the same edge.
- Arithmetic widths:
  - Candidate coordinates are 11-bit signed: cx±ox spans −255..510.
  - crit is 12-bit signed.
  - No wrap-around may produce a false on-screen pixel. For example, cx=5, ox=10 gives −5, which is clipped and never becomes 251.
- Duplicate pixels are emitted as-is and are not de-duplicated. This occurs for radius 0 and on the axis points.
- Reset at any time: next state IDLE; `done`=0, `vga_plot`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0.

## Timing
- All outputs are registered.
- Pixel timing: for `start` sampled at edge k, the first pixel is on the outputs after edge k+1, and one pixel follows per cycle.
- Drawing takes N iterations, where N = number of loop passes, for 8·N DRAW cycles.
- Done timing: `done` rises after edge k+8N+1, and `vga_plot` is 0 in that cycle.
- Ack timing: `start` low sampled at edge m drops `done` after edge m. A new `start` is accepted no earlier than edge m+1.
- Back-to-back requests: `start` held high continuously never triggers a second drawing; it must see IDLE.
- Cycles with no pending pixel (IDLE, DONE) have `vga_plot`=0.

## Test plan
- Radius 0, centre (80,60), colour 2:
  - exactly 8 cycles of `vga_plot`=1, all at (80,60) colour 2
  - `done` high on cycle 9 after the start edge
- Radius 1, centre (80,60): N=2, 16 DRAW cycles.
  - First 8 pixels: (81,60),(80,61),(79,60),(80,61),(79,60),(80,59),(81,60),(80,59).
  - Then `done` rises.
- Clipping at the corner, centre (0,0), radius 10:
  - no plotted pixel has negative or wrapped coordinates
  - every plotted pixel has x ≤ 10 and y ≤ 10
  - `done` asserts after 8·N cycles
- Fully off-screen, centre (200,60), radius 30:
  - zero `vga_plot` pulses
  - `done` still asserts after 8·N cycles
- Handshake:
  - Hold `start` 20 cycles past `done`: `done` stays high and no pixels appear.
  - Change `centre_x`, `centre_y`, `radius` and `colour` mid-DRAW: the output pixels are unaffected.
  - Drop `start`: `done` falls next edge.
- Reset mid-DRAW (radius 50, `rst` pulsed at pixel 100):
  - next cycle `vga_plot`=0 and `done`=0
  - a following request redraws from the first octant
